// File: rtl/simd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simd_pkg
//  Brief    : Shared constants and types for the SIMD instruction queue,
//             decoder and test bench.
//  Revision : 1.0 - initial release
// ============================================================================
package simd_pkg;

  // Instruction word width shared by the queue and the decoder.
  localparam int SIMD_IW = 16;

  // All-zero word decodes as NOP; driven by the queue whenever it is empty.
  localparam logic [SIMD_IW-1:0] SIMD_NOP = 16'h0000;

  // Opcode field encodings.
  typedef enum logic [3:0] {
    OP_NOP      = 4'b0000,
    OP_PADD     = 4'b0001,
    OP_PSUB     = 4'b0010,
    OP_PSLL     = 4'b0011,
    OP_PSRL     = 4'b0100,
    OP_PSRA     = 4'b0101,
    OP_PCMPEQ   = 4'b0110,
    OP_PCMPGT   = 4'b0111,
    OP_PUNPKGLO = 4'b1000,
    OP_PUNPKGHI = 4'b1001
  } simd_op_e;

  // Highest legal data-mode encoding.
  localparam logic [2:0] SIMD_MODE_MAX = 3'b101;

endpackage : simd_pkg
`default_nettype wire

// File: rtl/simd_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : simd_inst_queue
//  Brief    : Circular instruction FIFO in front of the SIMD decoder. Presents
//             the oldest queued word, or NOP while empty. Flush discards all
//             entries and has priority over push and pop.
//  Revision : 1.0 - initial release
// ============================================================================
module simd_inst_queue
  import simd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = SIMD_IW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IW-1:0]              in_inst,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [IW-1:0]              out_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int            c_AW  = $clog2(DEPTH);
  localparam int            c_CW  = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [IW-1:0] c_NOP = IW'(SIMD_NOP);

  logic [IW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Status flags come from registered occupancy only, so a same-cycle pop
  // never frees a slot and a same-cycle push is never visible.
  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != '0);
  assign out_inst  = out_valid ? r_mem[r_rd_ptr] : c_NOP;
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Storage write; contents are never cleared, pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= in_inst;
    end
  end

  // Pointer and occupancy update; flush overrides any push/pop this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : simd_inst_queue
`default_nettype wire

// File: tb/tb_simd_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simd_inst_queue
//  Brief    : Directed vector bench for simd_inst_queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simd_inst_queue;
  import simd_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 16;

  logic          clk;
  logic          rst;
  logic [IW-1:0] in_inst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] out_inst;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [2:0]    count;

  int n_checks;
  int n_errors;

  typedef struct {
    logic          v;      // in_valid
    logic [IW-1:0] d;      // in_inst
    logic          r;      // out_ready
    logic          f;      // flush
    logic [2:0]    e_cnt;  // expected count after the edge
    logic          e_ov;   // expected out_valid
    logic [IW-1:0] e_oi;   // expected out_inst
    logic          e_ir;   // expected in_ready
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  simd_inst_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_inst   (in_inst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_inst  (out_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] e_cnt, input logic e_ov,
                             input logic [IW-1:0] e_oi, input logic e_ir);
    check({tag, " count"},     32'(count),     32'(e_cnt));
    check({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    check({tag, " out_inst"},  32'(out_inst),  32'(e_oi));
    check({tag, " in_ready"},  32'(in_ready),  32'(e_ir));
  endtask

  // Drive at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [IW-1:0] d, input logic r, input logic f);
    @(negedge clk);
    in_valid  = v;
    in_inst   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_inst   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;

    //             v     d         r     f     cnt   ov    oi        ir
    // single pass-through
    vecs[0]  = '{1'b1, 16'h1203, 1'b0, 1'b0, 3'd1, 1'b1, 16'h1203, 1'b1};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1};
    // fill to full (write pointer wraps past DEPTH-1)
    vecs[2]  = '{1'b1, 16'h1000, 1'b0, 1'b0, 3'd1, 1'b1, 16'h1000, 1'b1};
    vecs[3]  = '{1'b1, 16'h2000, 1'b0, 1'b0, 3'd2, 1'b1, 16'h1000, 1'b1};
    vecs[4]  = '{1'b1, 16'h3000, 1'b0, 1'b0, 3'd3, 1'b1, 16'h1000, 1'b1};
    vecs[5]  = '{1'b1, 16'h4000, 1'b0, 1'b0, 3'd4, 1'b1, 16'h1000, 1'b0};
    // fifth word held while full, not accepted
    vecs[6]  = '{1'b1, 16'h5000, 1'b0, 1'b0, 3'd4, 1'b1, 16'h1000, 1'b0};
    // pop while full: no same-cycle slot reuse
    vecs[7]  = '{1'b1, 16'h5000, 1'b1, 1'b0, 3'd3, 1'b1, 16'h2000, 1'b1};
    vecs[8]  = '{1'b1, 16'h5000, 1'b0, 1'b0, 3'd4, 1'b1, 16'h2000, 1'b0};
    // drain in order
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b1, 16'h3000, 1'b1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd2, 1'b1, 16'h4000, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b1, 16'h5000, 1'b1};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1};
    // simultaneous push/pop at count = 2
    vecs[13] = '{1'b1, 16'hA100, 1'b0, 1'b0, 3'd1, 1'b1, 16'hA100, 1'b1};
    vecs[14] = '{1'b1, 16'hA200, 1'b0, 1'b0, 3'd2, 1'b1, 16'hA100, 1'b1};
    vecs[15] = '{1'b1, 16'hA300, 1'b1, 1'b0, 3'd2, 1'b1, 16'hA200, 1'b1};
    vecs[16] = '{1'b1, 16'hA400, 1'b1, 1'b0, 3'd2, 1'b1, 16'hA300, 1'b1};
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b1, 16'hA400, 1'b1};
    // build to count = 3, then flush with push and pop offered
    vecs[18] = '{1'b1, 16'hB100, 1'b0, 1'b0, 3'd2, 1'b1, 16'hA400, 1'b1};
    vecs[19] = '{1'b1, 16'hB200, 1'b0, 1'b0, 3'd3, 1'b1, 16'hA400, 1'b1};
    vecs[20] = '{1'b1, 16'h6000, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1};
    vecs[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1};
    vecs[22] = '{1'b1, 16'h6100, 1'b0, 1'b0, 3'd1, 1'b1, 16'h6100, 1'b1};
    vecs[23] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1};

    // reset then idle
    repeat (2) @(negedge clk);
    check_state("reset", 3'd0, 1'b0, 16'h0000, 1'b1);
    rst = 1'b0;
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check_state("idle", 3'd0, 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f);
      check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ov, vecs[i].e_oi, vecs[i].e_ir);
    end

    // asynchronous reset mid-stream with two words queued
    step(1'b1, 16'hC100, 1'b0, 1'b0);
    step(1'b1, 16'hC200, 1'b0, 1'b0);
    check_state("pre_rst", 3'd2, 1'b1, 16'hC100, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_state("async_rst", 3'd0, 1'b0, 16'h0000, 1'b1);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_inst  = 16'h7000;
    @(posedge clk);
    #1;
    check_state("post_rst", 3'd1, 1'b1, 16'h7000, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_state("post_rst_pop", 3'd0, 1'b0, 16'h0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_simd_inst_queue
`default_nettype wire
